// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: PC generator link, in-order instruction-memory read port
// and the decode valid/ready handshake.
interface ifetch_queue_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
);
  logic [PC_WIDTH-1:0]   pc_in;
  logic                  flush;
  logic                  hold_o;
  logic                  mem_req;
  logic [PC_WIDTH-1:0]   mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [INST_WIDTH-1:0] mem_rdata;
  logic                  inst_valid;
  logic [PC_WIDTH-1:0]   inst_pc;
  logic [INST_WIDTH-1:0] inst_data;
  logic                  inst_ready;

  modport slave (
    input  pc_in, flush, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
    output hold_o, mem_req, mem_addr, inst_valid, inst_pc, inst_data
  );

  modport master (
    output pc_in, flush, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
    input  hold_o, mem_req, mem_addr, inst_valid, inst_pc, inst_data
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order reads at the current PC, buffers
// {pc, instruction} pairs in a ring and drops stale responses after a redirect.
module ifetch_queue #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         fill_ptr_q, fill_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic [DEPTH-1:0]      filled_q, filled_d;
  logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];
  logic [INST_WIDTH-1:0] data_mem_q [DEPTH];

  logic          alloc;
  logic          pop;
  logic          fill;
  logic          head_valid;
  logic [AW-1:0] ptr_gap;
  logic [CW-1:0] unfilled;
  logic [CW:0]   occupancy;

  // Equal pointers with a full ring are ambiguous: either every entry is
  // filled or none is, and the fill bit at fill_ptr tells which.
  assign ptr_gap = wr_ptr_q - fill_ptr_q;
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    unfilled = {1'b0, ptr_gap};
    if (wr_ptr_q == fill_ptr_q && count_q == DEPTH_CNT && !filled_q[fill_ptr_q]) begin
      unfilled = DEPTH_CNT;
    end
  end

  assign occupancy    = {1'b0, count_q} + {1'b0, discard_q};
  assign bus.mem_req  = !rst && !bus.flush && (occupancy < DEPTH_OCC);
  assign bus.mem_addr = bus.pc_in;
  assign alloc        = bus.mem_req && bus.mem_gnt;
  assign bus.hold_o   = rst || (!bus.flush && !alloc);

  assign head_valid     = !rst && filled_q[rd_ptr_q] && (count_q != '0);
  assign bus.inst_valid = head_valid;
  assign bus.inst_pc    = rst ? '0 : pc_mem_q[rd_ptr_q];
  assign bus.inst_data  = rst ? '0 : data_mem_q[rd_ptr_q];
  assign pop            = head_valid && bus.inst_ready && !bus.flush;
  assign fill           = bus.mem_rvalid && (discard_q == '0) && !bus.flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    discard_d  = discard_q;
    filled_d   = filled_q;
    if (bus.flush) begin
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      filled_d   = '0;
      discard_d  = discard_q + unfilled - CW'(bus.mem_rvalid);
    end else begin
      if (bus.mem_rvalid && discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end
      if (fill) begin
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + AW'(1);
      end
      if (alloc) begin
        filled_d[wr_ptr_q] = 1'b0;
        wr_ptr_d           = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = rd_ptr_q + AW'(1);
      end
      case ({alloc, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      discard_q  <= '0;
      filled_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
      filled_q   <= filled_d;
    end
  end

  // NOTE: ring storage has no reset; filled_q gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (alloc) pc_mem_q[wr_ptr_q] <= bus.pc_in;
    if (fill)  data_mem_q[fill_ptr_q] <= bus.mem_rdata;
  end

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
    bus.mem_rvalid |-> (discard_q != '0 || unfilled != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_ifetch_queue;
  localparam int PW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_queue_if #(.PC_WIDTH(PW), .INST_WIDTH(IW)) bus ();

  ifetch_queue #(.PC_WIDTH(PW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] pc;
  logic [31:0] target;

  typedef struct {
    logic        fl, gnt, rv;
    logic [31:0] rd;
    logic        rdy;
    logic        req, hold;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc, idata;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          has;
  } ent_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Drive one cycle's inputs and wait until outputs are settled mid-cycle.
  task automatic apply(input logic fl, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic rdy);
    bus.flush      = fl;
    bus.mem_gnt    = gnt;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rd;
    bus.inst_ready = rdy;
    @(negedge clk);
  endtask

  // PC generator: branch on flush, otherwise advance unless held.
  task automatic adv();
    logic h, f;
    h = bus.hold_o;
    f = bus.flush;
    @(posedge clk);
    #1;
    if (f) pc = target;
    else if (!h) pc = pc + 32'd4;
    bus.pc_in = pc;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.inst_ready = 1'b0;
    pc             = '0;
    bus.pc_in      = '0;
    #1;
    check("rst_hold", bus.hold_o, 1);
    check("rst_req", bus.mem_req, 0);
    check("rst_valid", bus.inst_valid, 0);
    check("rst_ipc", bus.inst_pc, 0);
    check("rst_idata", bus.inst_data, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  vec_t tbl[10];
  ent_t mq[$];
  int   mdisc;
  logic [31:0] pend[$];

  initial begin
    rst    = 1'b1;
    target = '0;

    // ---------------- streaming from reset, vector table ----------------
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0,  32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, mw(32'h0),  1'b1, 1'b1, 1'b0, 32'h04, 1'b0, 32'h0,  32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, mw(32'h4),  1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h0,  mw(32'h0)};
    tbl[3] = '{1'b0, 1'b1, 1'b1, mw(32'h8),  1'b1, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h4,  mw(32'h4)};
    tbl[4] = '{1'b0, 1'b1, 1'b1, mw(32'hC),  1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8,  mw(32'h8)};
    tbl[5] = '{1'b0, 1'b0, 1'b1, mw(32'h10), 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC,  mw(32'hC)};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 32'h10, mw(32'h10)};
    tbl[7] = '{1'b0, 1'b0, 1'b1, mw(32'h14), 1'b1, 1'b1, 1'b1, 32'h18, 1'b0, 32'h0,  32'h0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h14, mw(32'h14)};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 32'h18, 1'b0, 32'h0,  32'h0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].fl, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].rdy);
      check($sformatf("tbl%0d_req", i), bus.mem_req, tbl[i].req);
      check($sformatf("tbl%0d_hold", i), bus.hold_o, tbl[i].hold);
      check($sformatf("tbl%0d_addr", i), bus.mem_addr, tbl[i].addr);
      check($sformatf("tbl%0d_valid", i), bus.inst_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        check($sformatf("tbl%0d_ipc", i), bus.inst_pc, tbl[i].ipc);
        check($sformatf("tbl%0d_idata", i), bus.inst_data, tbl[i].idata);
      end
      adv();
    end

    // ---------------- ring full with decode stalled ----------------
    do_reset();
    for (int c = 0; c < 7; c++) begin
      logic rv;
      rv = (c >= 1 && c <= 4);
      apply(1'b0, 1'b1, rv, mw(32'((c - 1) * 4)), c == 5);
      if (c < 4) begin
        check($sformatf("full%0d_req", c), bus.mem_req, 1);
        check($sformatf("full%0d_addr", c), bus.mem_addr, 32'(c * 4));
        check($sformatf("full%0d_hold", c), bus.hold_o, 0);
      end else if (c < 6) begin
        check($sformatf("full%0d_req", c), bus.mem_req, 0);
        check($sformatf("full%0d_hold", c), bus.hold_o, 1);
        check($sformatf("full%0d_addr", c), bus.mem_addr, 32'h10);
      end else begin
        check("full_resume_req", bus.mem_req, 1);
        check("full_resume_addr", bus.mem_addr, 32'h10);
        check("full_resume_hold", bus.hold_o, 0);
      end
      if (c == 5) begin
        check("full_head_valid", bus.inst_valid, 1);
        check("full_head_pc", bus.inst_pc, 32'h0);
      end
      adv();
    end

    // ---------------- grant stall, then flush with two outstanding ----------------
    do_reset();
    apply(1'b0, 1'b1, 1'b0, '0, 1'b1); adv();
    apply(1'b0, 1'b1, 1'b0, '0, 1'b1); adv();
    for (int c = 0; c < 5; c++) begin
      apply(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check($sformatf("stall%0d_req", c), bus.mem_req, 1);
      check($sformatf("stall%0d_hold", c), bus.hold_o, 1);
      check($sformatf("stall%0d_addr", c), bus.mem_addr, 32'h8);
      check($sformatf("stall%0d_valid", c), bus.inst_valid, 0);
      adv();
    end
    target = 32'h100;
    apply(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("fl_hold", bus.hold_o, 0);
    check("fl_req", bus.mem_req, 0);
    adv();
    apply(1'b0, 1'b1, 1'b0, '0, 1'b1);
    check("fl1_addr", bus.mem_addr, 32'h100);
    check("fl1_req", bus.mem_req, 1);
    check("fl1_valid", bus.inst_valid, 0);
    adv();
    apply(1'b0, 1'b1, 1'b1, 32'hBAD0_0000, 1'b1);
    check("fl2_addr", bus.mem_addr, 32'h104);
    check("fl2_valid", bus.inst_valid, 0);
    adv();
    apply(1'b0, 1'b1, 1'b1, 32'hBAD0_0004, 1'b1);
    check("fl3_addr", bus.mem_addr, 32'h108);
    check("fl3_valid", bus.inst_valid, 0);
    adv();
    apply(1'b0, 1'b1, 1'b1, mw(32'h100), 1'b1);
    check("fl4_req", bus.mem_req, 1);
    check("fl4_valid", bus.inst_valid, 0);
    adv();
    apply(1'b0, 1'b1, 1'b1, mw(32'h104), 1'b1);
    check("fl5_req", bus.mem_req, 0);
    check("fl5_valid", bus.inst_valid, 1);
    check("fl5_ipc", bus.inst_pc, 32'h100);
    check("fl5_idata", bus.inst_data, mw(32'h100));
    adv();
    apply(1'b0, 1'b1, 1'b1, mw(32'h108), 1'b1);
    check("fl6_addr", bus.mem_addr, 32'h110);
    check("fl6_ipc", bus.inst_pc, 32'h104);
    check("fl6_idata", bus.inst_data, mw(32'h104));
    adv();

    // ---------------- flush with concurrent rvalid and pop ----------------
    do_reset();
    target = 32'h200;
    apply(1'b0, 1'b1, 1'b0, '0, 1'b0); adv();
    apply(1'b0, 1'b1, 1'b1, mw(32'h0), 1'b0); adv();
    apply(1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("cf2_valid", bus.inst_valid, 1);
    check("cf2_ipc", bus.inst_pc, 32'h0);
    adv();
    apply(1'b1, 1'b0, 1'b1, mw(32'h4), 1'b1);
    check("cf3_hold", bus.hold_o, 0);
    check("cf3_req", bus.mem_req, 0);
    adv();
    apply(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("cf4_valid", bus.inst_valid, 0);
    check("cf4_addr", bus.mem_addr, 32'h200);
    check("cf4_hold", bus.hold_o, 1);
    adv();
    apply(1'b0, 1'b1, 1'b1, mw(32'h8), 1'b1);
    check("cf5_valid", bus.inst_valid, 0);
    check("cf5_req", bus.mem_req, 1);
    adv();
    apply(1'b0, 1'b0, 1'b1, mw(32'h200), 1'b1);
    check("cf6_valid", bus.inst_valid, 0);
    adv();
    apply(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("cf7_valid", bus.inst_valid, 1);
    check("cf7_ipc", bus.inst_pc, 32'h200);
    check("cf7_idata", bus.inst_data, mw(32'h200));
    adv();
    apply(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("cf8_valid", bus.inst_valid, 0);
    adv();

    // ---------------- asynchronous reset with three buffered ----------------
    do_reset();
    apply(1'b0, 1'b1, 1'b0, '0, 1'b0); adv();
    apply(1'b0, 1'b1, 1'b1, mw(32'h0), 1'b0); adv();
    apply(1'b0, 1'b1, 1'b1, mw(32'h4), 1'b0); adv();
    apply(1'b0, 1'b0, 1'b1, mw(32'h8), 1'b0); adv();
    apply(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("ar_pre_valid", bus.inst_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", bus.inst_valid, 0);
    check("ar_req", bus.mem_req, 0);
    check("ar_hold", bus.hold_o, 1);
    check("ar_ipc", bus.inst_pc, 0);
    repeat (2) @(posedge clk);
    #3;
    pc        = 32'h40;
    bus.pc_in = pc;
    rst       = 1'b0;
    #1;
    check("ar_rel_req", bus.mem_req, 1);
    check("ar_rel_valid", bus.inst_valid, 0);
    for (int c = 0; c < 5; c++) begin
      apply(1'b0, 1'b1, 1'b0, '0, 1'b0);
      check($sformatf("ar%0d_req", c), bus.mem_req, c < 4);
      if (c < 4) check($sformatf("ar%0d_addr", c), bus.mem_addr, 32'h40 + 32'(c * 4));
      adv();
    end
    apply(1'b0, 1'b0, 1'b1, mw(32'h40), 1'b0); adv();
    apply(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("ar_first_pc", bus.inst_pc, 32'h40);
    check("ar_first_data", bus.inst_data, mw(32'h40));
    adv();

    // ---------------- randomized run against reference model ----------------
    do_reset();
    mq.delete();
    pend.delete();
    mdisc = 0;
    for (int n = 0; n < 3000; n++) begin
      logic fl, gnt, rv, rdy, mv, mreq, mhold, dreq;
      logic [31:0] rd;
      fl  = ($urandom_range(0, 19) == 0);
      gnt = ($urandom_range(0, 3) != 0);
      rv  = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
      rd  = rv ? mw(pend[0]) : $urandom;
      rdy = ($urandom_range(0, 4) < 3);
      if (fl) target = 32'($urandom_range(0, 16383)) << 2;
      apply(fl, gnt, rv, rd, rdy);

      mv    = (mq.size() > 0) && mq[0].has;
      mreq  = !fl && (mq.size() + mdisc < DEPTH);
      mhold = !fl && !(mreq && gnt);
      check("rnd_req", bus.mem_req, mreq);
      check("rnd_hold", bus.hold_o, mhold);
      check("rnd_addr", bus.mem_addr, pc);
      check("rnd_valid", bus.inst_valid, mv);
      if (mv) begin
        check("rnd_ipc", bus.inst_pc, mq[0].pc);
        check("rnd_idata", bus.inst_data, mq[0].data);
      end

      if (fl) begin
        int u;
        u = 0;
        foreach (mq[i]) if (!mq[i].has) u++;
        mdisc = mdisc + u - (rv ? 1 : 0);
        mq.delete();
      end else begin
        if (rv) begin
          if (mdisc > 0) mdisc--;
          else begin
            bit done;
            done = 0;
            for (int i = 0; i < mq.size(); i++) begin
              if (!done && !mq[i].has) begin
                mq[i].data = rd;
                mq[i].has  = 1;
                done       = 1;
              end
            end
          end
        end
        if (mv && rdy) void'(mq.pop_front());
        if (mreq && gnt) mq.push_back('{pc, 32'h0, 1'b0});
      end

      dreq = bus.mem_req;
      if (dreq && gnt) pend.push_back(pc);
      if (rv) void'(pend.pop_front());
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
